// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
package pipe_hazard_pkg;

   localparam int DEF_REG_AW   = 5;
   localparam int DEF_DEPTH    = 3;
   localparam int DEF_LOAD_LAT = 1;
   localparam int FWD_RF       = 0;

   // Scoreboard dest field is sized for the widest register address supported.
   localparam int MAX_REG_AW   = 8;

   typedef struct packed {
      logic                  valid;
      logic [MAX_REG_AW-1:0] dest;
      logic                  wen;
      logic                  is_load;
   } sb_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - youngest-wins scoreboard match and forwardability for one source
module hazard_src_match
   import pipe_hazard_pkg::*;
#(
   parameter int REG_AW   = DEF_REG_AW,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int LOAD_LAT = DEF_LOAD_LAT,
   parameter int SEL_W    = $clog2(DEPTH + 1)
) (
   input  logic                  use_src,
   input  logic [REG_AW-1:0]     src,
   input  sb_entry_t [DEPTH-1:0] sb,
   output logic                  hit,
   output logic                  fwd_ok,
   output logic [SEL_W-1:0]      sel
);

   logic src_live;

   assign src_live = use_src && (src != '0);

   // Walk oldest to youngest so the lowest matching entry is the one left standing.
   always_comb begin
      hit    = 1'b0;
      fwd_ok = 1'b1;
      sel    = SEL_W'(FWD_RF);
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (src_live && sb[k].valid && sb[k].wen &&
             (sb[k].dest == MAX_REG_AW'(src))) begin
            hit    = 1'b1;
            fwd_ok = !sb[k].is_load || (k >= LOAD_LAT);
            sel    = SEL_W'(k + 1);
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, redirect flush and forward select; HAZARD_PERF_EN adds stall_cnt
module pipe_hazard_ctrl
   import pipe_hazard_pkg::*;
#(
   parameter int REG_AW   = DEF_REG_AW,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int LOAD_LAT = DEF_LOAD_LAT,
   parameter int SEL_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
`ifdef HAZARD_PERF_EN
   output logic [31:0]       stall_cnt,
`endif
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_wen,
   input  logic              id_is_load,
   input  logic              ex_redirect,
   output logic              stall,
   output logic              flush_fd,
   output logic              ex_bubble,
   output logic [SEL_W-1:0]  fwd_sel1,
   output logic [SEL_W-1:0]  fwd_sel2
);

   sb_entry_t [DEPTH-1:0] sb;
   sb_entry_t             id_entry;
   logic                  hit1, hit2;
   logic                  ok1, ok2;
   logic [SEL_W-1:0]      sel1, sel2;
   logic                  advance;

   hazard_src_match #(
      .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
   ) u_match1 (
      .use_src(id_use1), .src(id_src1), .sb(sb),
      .hit(hit1), .fwd_ok(ok1), .sel(sel1)
   );

   hazard_src_match #(
      .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
   ) u_match2 (
      .use_src(id_use2), .src(id_src2), .sb(sb),
      .hit(hit2), .fwd_ok(ok2), .sel(sel2)
   );

   // Redirect dominates any hazard; reset forces stall low without a clock.
   assign stall    = rst && id_valid && !ex_redirect && ((hit1 && !ok1) || (hit2 && !ok2));
   assign flush_fd = ex_redirect;
   assign advance  = id_valid && !stall && !ex_redirect;

   always_comb begin
      id_entry         = '0;
      id_entry.valid   = 1'b1;
      id_entry.dest    = MAX_REG_AW'(id_dest);
      id_entry.wen     = id_wen;
      id_entry.is_load = id_is_load;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb        <= '0;
         fwd_sel1  <= SEL_W'(FWD_RF);
         fwd_sel2  <= SEL_W'(FWD_RF);
         ex_bubble <= 1'b1;
      end else begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            sb[k] <= sb[k-1];
         end
         sb[0]     <= advance ? id_entry : '0;
         fwd_sel1  <= (advance && hit1) ? sel1 : SEL_W'(FWD_RF);
         fwd_sel2  <= (advance && hit2) ? sel2 : SEL_W'(FWD_RF);
         ex_bubble <= !advance;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width.
REQ-002 SHALL have parameter DEPTH, default 3: tracked stages after ID (EX..WB), range 2..6.
REQ-003 SHALL have parameter LOAD_LAT, default 1: extra stages past EX before load data is forwardable, range 1..DEPTH-1.
REQ-004 SHALL have parameter SEL_W, default $clog2(DEPTH+1): forward-select width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset. Port names are clk and rst.
REQ-006 clk, input, 1: rising-edge clock.
REQ-007 rst, input, 1: asynchronous, active-low reset.
REQ-008 id_valid, input, 1: ID holds a real instruction.
REQ-009 id_src1 / id_src2, input, REG_AW each: source registers.
REQ-010 id_use1 / id_use2, input, 1 each: source actually read.
REQ-011 id_dest, input, REG_AW: destination register.
REQ-012 id_wen, input, 1: instruction writes id_dest.
REQ-013 id_is_load, input, 1: instruction is a load.
REQ-014 ex_redirect, input, 1: taken branch/jump resolved in EX.
REQ-015 stall, output, 1: hold PC and F/D.
REQ-016 flush_fd, output, 1: kill F/D contents.
REQ-017 ex_bubble, output, 1: EX holds a bubble.
REQ-018 fwd_sel1 / fwd_sel2, output, SEL_W each: EX operand source. 0 = register file; k = output of stage EX+k.
REQ-019 stall_cnt, output, 32: only with HAZARD_PERF_EN.

Function
REQ-020 SHALL keep scoreboard entries 0..DEPTH-1, each {valid, dest, wen, is_load}. Entry k = instruction in stage EX+k.
REQ-021 Every cycle, entries SHALL shift k->k+1 and entry DEPTH-1 is discarded, whether or not there is a stall.
REQ-022 Entry 0 SHALL load the ID instruction when id_valid & !stall & !ex_redirect; otherwise it SHALL load a bubble (valid=0).
REQ-023 A source matches entry k when id_useN, valid, wen, dest==srcN and srcN!=0; the lowest k (youngest) SHALL win.
REQ-024 A match at entry k is forwardable if !is_load, or if is_load and k>=LOAD_LAT.
REQ-025 stall SHALL be combinational: id_valid & !ex_redirect & (any winning match is not forwardable).
REQ-026 fwd_selN SHALL be registered. On ID->EX advance it takes k+1 for the winning match, or 0 if there is no match; on a bubble it takes 0.
REQ-027 ex_bubble SHALL be registered and equal !(new entry 0 valid).
REQ-028 flush_fd SHALL equal ex_redirect combinationally.
REQ-029 When ex_redirect and a hazard occur together, the redirect SHALL win: stall=0 and the ID instruction becomes a bubble.
REQ-030 A load-use stall SHALL persist cycle by cycle until the producer reaches entry LOAD_LAT, then release with no extra cycle.
REQ-031 A producer beyond entry DEPTH-1 SHALL yield fwd_sel=0 (register file written before read).
REQ-032 Latency: stall and flush_fd are 0-cycle (combinational); scoreboard, fwd_sel and ex_bubble update 1 cycle later.

Reset
REQ-033 While rst=0, all entries SHALL be invalid, fwd_sel1/2=0, ex_bubble=1 and stall_cnt=0, asynchronously.
REQ-034 The stall output SHALL be 0 during reset regardless of inputs.
REQ-035 Reset deassertion SHALL take effect at the next rising clk; no state survives a mid-stall reset.

Configuration
REQ-036 With HAZARD_PERF_EN defined, stall_cnt SHALL increment on each cycle with stall=1 and saturate at 32'hFFFFFFFF.
REQ-037 Without HAZARD_PERF_EN, the stall_cnt port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-038 Package pipe_hazard_pkg SHALL hold the scoreboard entry typedef, the FWD_RF=0 constant and default parameter values.
REQ-039 Sub-module hazard_src_match SHALL do the priority match plus forwardability check for one source; it is instantiated twice.
REQ-040 Outputs of the two hazard_src_match instances SHALL be combined only in pipe_hazard_ctrl; no logic is duplicated.

Verification (DEPTH=3, LOAD_LAT=1)
REQ-041 ADD r3 then ADD using src1=r3 back-to-back -> stall=0, next-cycle fwd_sel1=1.
REQ-042 LW r5 then ADD using src2=r5 -> stall=1 for exactly 1 cycle, ex_bubble=1, then fwd_sel2=2.
REQ-043 Writer r0 then reader r0 -> stall=0, fwd_sel=0.
REQ-044 LW r7 with hazard and ex_redirect=1 in the same cycle -> stall=0, flush_fd=1, ex_bubble=1 next cycle.
REQ-045 ADD r4, nop, nop, nop, then reader r4 -> fwd_sel1=0; back-to-back writers r4 -> the youngest is selected (fwd_sel1=1).
REQ-046 With HAZARD_PERF_EN: 3 load-use stalls -> stall_cnt=3; assert rst mid-stall -> stall_cnt=0, stall=0 immediately.
